// File: rtl/metaball_scanner_if.sv
// Metaball sample bus: the scanner broadcasts a sample position and strobe,
// and each evaluator answers with a completion flag and its Q17.15 contribution.
interface metaball_scanner_if #(
    parameter int N_BALLS = 4
);
    logic                   px_stb;
    logic [31:0]            p_x;
    logic [31:0]            p_y;
    logic [N_BALLS-1:0]     vld;
    logic [32*N_BALLS-1:0]  contrib;
    logic                   mov_en;

    modport master (
        output px_stb, p_x, p_y, mov_en,
        input  vld, contrib
    );

    modport slave (
        input  px_stb, p_x, p_y, mov_en,
        output vld, contrib
    );
endinterface

// File: rtl/metaball_scanner.sv
// Raster-order metaball scanner: strobes each pixel position to the evaluators,
// thresholds their saturated sum into a 1-bit framebuffer, then pulses mov_en.
module metaball_scanner #(
    parameter int          WIDTH_PX  = 32,
    parameter int          HEIGHT_PX = 64,
    parameter int          N_BALLS   = 4,
    parameter logic [31:0] THRESH    = 32'h0000_8000,
    parameter int          TIMEOUT   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   frame_go,
    metaball_scanner_if.master                     smp,
    output logic                                   wr_en,
    output logic [$clog2(WIDTH_PX*HEIGHT_PX)-1:0]  wr_addr,
    output logic                                   wr_data,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   err
);
    localparam int AW  = $clog2(WIDTH_PX*HEIGHT_PX);
    localparam int CW  = (WIDTH_PX  > 1) ? $clog2(WIDTH_PX)  : 1;
    localparam int RW  = (HEIGHT_PX > 1) ? $clog2(HEIGHT_PX) : 1;
    localparam int WTW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_BLANK, S_WAIT, S_SUM, S_WRITE, S_MOVE, S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [WTW-1:0]  wait_cnt;
    logic [31:0]     sum_p1;
    logic [AW-1:0]   pix_addr;
    logic            last_col;
    logic            last_px;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Clamping after every lane keeps the result monotonic regardless of lane order.
    function automatic logic [31:0] lane_sum(input logic [32*N_BALLS-1:0] c);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < N_BALLS; i++)
            acc = sat_add(acc, c[32*i +: 32]);
        return acc;
    endfunction

    assign pix_addr = AW'(int'(row) * WIDTH_PX + int'(col));
    assign last_col = (col == CW'(WIDTH_PX - 1));
    assign last_px  = last_col && (row == RW'(HEIGHT_PX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            wait_cnt   <= '0;
            sum_p1     <= '0;
            smp.px_stb <= 1'b0;
            smp.p_x    <= '0;
            smp.p_y    <= '0;
            smp.mov_en <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            smp.px_stb <= 1'b0;
            smp.mov_en <= 1'b0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_go) begin
                        col        <= '0;
                        row        <= '0;
                        smp.p_x    <= '0;
                        smp.p_y    <= '0;
                        smp.px_stb <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_STROBE;
                    end
                end
                S_STROBE: state <= S_BLANK;
                // vld may still be high from the previous pixel; it is not looked at here.
                S_BLANK: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (&smp.vld) begin
                        sum_p1 <= lane_sum(smp.contrib);
                        state  <= S_SUM;
                    end else if (wait_cnt == WTW'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_addr <= pix_addr;
                        wr_data <= 1'b0;
                        state   <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SUM: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_addr;
                    wr_data <= (sum_p1 >= THRESH);
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (last_px) begin
                        smp.mov_en <= 1'b1;
                        state      <= S_MOVE;
                    end else begin
                        if (last_col) begin
                            col     <= '0;
                            row     <= row + 1'b1;
                            smp.p_x <= '0;
                            smp.p_y <= 32'(row + 1'b1) << 15;
                        end else begin
                            col     <= col + 1'b1;
                            smp.p_x <= 32'(col + 1'b1) << 15;
                        end
                        smp.px_stb <= 1'b1;
                        state      <= S_STROBE;
                    end
                end
                S_MOVE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
